// File: rtl/quad_decoder.sv
// Quadrature encoder front end: per-phase synchronizer, glitch filter and
// Gray-code step decoder driving an 8-bit wrapping position counter.
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       quad_a,
    input  logic       quad_b,
    input  logic       enable,
    input  logic       clear,
    input  logic       err_clr,
    output logic       step,
    output logic       direction,
    output logic [7:0] position,
    output logic       error
);

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN);

    logic [SYNC_STAGES-1:0] sync_a_q;
    logic [SYNC_STAGES-1:0] sync_b_q;
    logic [1:0]             pair_s;

    logic [1:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] filt_q, filt_d;
    logic       acc_q, acc_d;

    logic [1:0] state_q, state_d;
    logic       first_q, first_d;
    logic       step_q, step_d;
    logic       dir_q, dir_d;
    logic [7:0] pos_q, pos_d;
    logic       err_q, err_d;

    logic       up_s;
    logic       down_s;
    logic       illegal_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], quad_a};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], quad_b};
        end
    end

    assign pair_s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // A candidate pair is accepted exactly once, on the edge its run length reaches FILTER_LEN.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        acc_d  = 1'b0;
        filt_d = filt_q;
        if (pair_s != cand_q) begin
            cand_d = pair_s;
            cnt_d  = 4'd1;
            acc_d  = (FILTER_LEN == 1);
        end else if (cnt_q < FILT_MAX) begin
            cnt_d = cnt_q + 4'd1;
            acc_d = (cnt_d == FILT_MAX);
        end
        if (acc_d) begin
            filt_d = pair_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q <= '0;
            cnt_q  <= '0;
            filt_q <= '0;
            acc_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            acc_q  <= acc_d;
        end
    end

    always_comb begin
        up_s      = 1'b0;
        down_s    = 1'b0;
        illegal_s = 1'b0;
        if (acc_q && !first_q) begin
            case ({state_q, filt_q})
                {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: up_s      = 1'b1;
                {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: down_s    = 1'b1;
                {S00, S11}, {S11, S00}, {S01, S10}, {S10, S01}: illegal_s = 1'b1;
                default: ;
            endcase
        end
    end

    // State keeps tracking with enable low so re-enabling never produces a stale step.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        pos_d   = pos_q;
        err_d   = err_q;
        if (acc_q) begin
            state_d = filt_q;
            first_d = 1'b0;
        end
        if (enable && (up_s || down_s)) begin
            step_d = 1'b1;
            dir_d  = up_s;
            pos_d  = up_s ? pos_q + 8'd1 : pos_q - 8'd1;
        end
        if (clear) begin
            pos_d = 8'd0;
        end
        if (illegal_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S00;
            first_q <= 1'b1;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            pos_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    assign step      = step_q;
    assign direction = dir_q;
    assign position  = pos_q;
    assign error     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios with literal
// expectations plus randomized stimulus compared against a behavioural model.
module tb_quad_decoder;

    localparam int SYNC = 2;
    localparam int FILT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       quadA = 1'b0;
    logic       quadB = 1'b0;
    logic       enableIn = 1'b1;
    logic       clearIn = 1'b0;
    logic       errClr = 1'b0;
    logic       step;
    logic       direction;
    logic [7:0] position;
    logic       errorOut;

    int checks = 0;
    int errors = 0;

    quad_decoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT)) dut (
        .clk       (clk),
        .rst       (rst),
        .quad_a    (quadA),
        .quad_b    (quadB),
        .enable    (enableIn),
        .clear     (clearIn),
        .err_clr   (errClr),
        .step      (step),
        .direction (direction),
        .position  (position),
        .error     (errorOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: inputs appear after SYNC edges, a value is accepted after
    // FILT identical samples, and steps follow the Gray-code index difference.
    logic       expStep = 1'b0;
    logic       expDir = 1'b1;
    logic [7:0] expPos = 8'd0;
    logic       expErr = 1'b0;
    logic [1:0] inHist[$];
    logic [1:0] smp[$];
    logic [1:0] mState = 2'b00;
    logic       mFirst = 1'b1;
    logic       pendValid = 1'b0;
    logic [1:0] pendVal = 2'b00;

    function automatic int grayIndex(input logic [1:0] p);
        case (p)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic modelReset();
        expStep = 1'b0;
        expDir = 1'b1;
        expPos = 8'd0;
        expErr = 1'b0;
        mState = 2'b00;
        mFirst = 1'b1;
        pendValid = 1'b0;
        inHist.delete();
        smp.delete();
        for (int i = 0; i < SYNC; i++) inHist.push_back(2'b00);
    endtask

    task automatic modelEdge();
        int delta;
        logic illegal;
        logic [1:0] synced;
        logic allSame;
        expStep = 1'b0;
        illegal = 1'b0;
        if (pendValid) begin
            if (mFirst) begin
                mFirst = 1'b0;
            end else begin
                delta = (grayIndex(pendVal) - grayIndex(mState) + 4) % 4;
                if (delta == 2) begin
                    illegal = 1'b1;
                end else if (delta != 0 && enableIn) begin
                    expStep = 1'b1;
                    expDir = (delta == 1);
                    expPos = (delta == 1) ? expPos + 8'd1 : expPos - 8'd1;
                end
            end
            mState = pendVal;
        end
        if (clearIn) expPos = 8'd0;
        if (illegal) expErr = 1'b1;
        else if (errClr) expErr = 1'b0;

        inHist.push_back({quadA, quadB});
        synced = inHist.pop_front();
        smp.push_back(synced);
        if (smp.size() > FILT + 1) void'(smp.pop_front());
        allSame = (smp.size() >= FILT);
        for (int i = smp.size() - FILT; i < smp.size() && allSame; i++) begin
            if (smp[i] != synced) allSame = 1'b0;
        end
        pendValid = allSame && (smp.size() == FILT || smp[0] != smp[1]);
        pendVal = synced;
    endtask

    always begin
        @(posedge clk or negedge rst);
        if (!rst) modelReset();
        else modelEdge();
    end

    always @(negedge clk) begin
        checkOutput("step", int'(step), int'(expStep));
        checkOutput("direction", int'(direction), int'(expDir));
        checkOutput("position", int'(position), int'(expPos));
        checkOutput("error", int'(errorOut), int'(expErr));
    end

    task automatic applyStimulus(input logic [1:0] p);
        {quadA, quadB} = p;
    endtask

    task automatic runCycles(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (step) pulses++;
        end
    endtask

    int p;
    int holdLeft;
    logic [7:0] upExp[4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [1:0] upSeq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] downSeq[3] = '{2'b00, 2'b10, 2'b11};
    logic [7:0] downExp[3] = '{8'd0, 8'd255, 8'd254};

    initial begin
        $display("[TB] start");
        runCycles(3, p);
        rst = 1'b1;
        runCycles(10, p);
        checkOutput("first accept silent", p, 0);
        checkOutput("first accept error", int'(errorOut), 0);

        // Clean up transitions: pulse lands on edge 6 after the change.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(upSeq[i]);
            runCycles(5, p);
            checkOutput("up early step", p, 0);
            runCycles(1, p);
            checkOutput("up step at edge 6", p, 1);
            checkOutput("up direction", int'(direction), 1);
            checkOutput("up position", int'(position), int'(upExp[i]));
            runCycles(4, p);
            checkOutput("up single pulse", p, 0);
        end

        clearIn = 1'b1;
        runCycles(1, p);
        clearIn = 1'b0;
        checkOutput("clear position", int'(position), 0);
        applyStimulus(2'b01);
        runCycles(10, p);
        checkOutput("position one", int'(position), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(downSeq[i]);
            runCycles(6, p);
            checkOutput("down step", p, 1);
            checkOutput("down direction", int'(direction), 0);
            checkOutput("down position", int'(position), int'(downExp[i]));
            runCycles(4, p);
        end

        applyStimulus(2'b01);
        runCycles(2, p);
        applyStimulus(2'b11);
        runCycles(12, p);
        checkOutput("glitch step", p, 0);
        checkOutput("glitch position", int'(position), 254);
        checkOutput("glitch error", int'(errorOut), 0);

        applyStimulus(2'b00);
        runCycles(10, p);
        checkOutput("jump step", p, 0);
        checkOutput("jump error", int'(errorOut), 1);
        checkOutput("jump position", int'(position), 254);
        errClr = 1'b1;
        runCycles(1, p);
        errClr = 1'b0;
        checkOutput("err_clr clears", int'(errorOut), 0);
        applyStimulus(2'b11);
        runCycles(5, p);
        errClr = 1'b1;
        runCycles(1, p);
        errClr = 1'b0;
        checkOutput("err_clr coincident", int'(errorOut), 1);
        runCycles(4, p);
        checkOutput("error sticky", int'(errorOut), 1);
        errClr = 1'b1;
        runCycles(1, p);
        errClr = 1'b0;

        enableIn = 1'b0;
        applyStimulus(2'b10);
        runCycles(10, holdLeft);
        applyStimulus(2'b00);
        runCycles(10, p);
        holdLeft += p;
        applyStimulus(2'b01);
        runCycles(10, p);
        holdLeft += p;
        checkOutput("disabled steps", holdLeft, 0);
        enableIn = 1'b1;
        applyStimulus(2'b11);
        runCycles(10, p);
        checkOutput("enabled step", p, 1);
        checkOutput("enabled position", int'(position), 255);
        checkOutput("enabled error", int'(errorOut), 0);

        applyStimulus(2'b10);
        runCycles(10, p);
        applyStimulus(2'b11);
        runCycles(3, p);
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset step", int'(step), 0);
        checkOutput("async reset direction", int'(direction), 1);
        checkOutput("async reset position", int'(position), 0);
        checkOutput("async reset error", int'(errorOut), 0);
        runCycles(2, p);
        rst = 1'b1;
        runCycles(12, p);
        checkOutput("post reset silent", p, 0);
        checkOutput("post reset error", int'(errorOut), 0);
        applyStimulus(2'b10);
        runCycles(5, p);
        clearIn = 1'b1;
        runCycles(1, p);
        clearIn = 1'b0;
        checkOutput("clear with step pulse", p, 1);
        checkOutput("clear with step position", int'(position), 0);
        checkOutput("clear with step direction", int'(direction), 1);

        holdLeft = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (holdLeft == 0) begin
                applyStimulus(2'($urandom_range(0, 3)));
                holdLeft = $urandom_range(1, 8);
            end
            holdLeft--;
            enableIn = ($urandom_range(0, 9) != 0);
            clearIn = ($urandom_range(0, 24) == 0);
            errClr = ($urandom_range(0, 9) == 0);
            if (i == 300) begin
                #3 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        runCycles(2, p);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops per quadrature input (legal 2..4).
REQ-002 Parameter FILTER_LEN, default 3, SHALL set the consecutive identical samples required before a synchronized input is accepted (legal 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 quad_a  input  1  SHALL be quadrature phase A, asynchronous to clk.
REQ-006 quad_b  input  1  SHALL be quadrature phase B, asynchronous to clk.
REQ-007 enable  input  1  SHALL gate step reporting and position update when 0.
REQ-008 clear  input  1  SHALL synchronously zero position.
REQ-009 err_clr  input  1  SHALL synchronously clear the error flag.
REQ-010 step  output  1  SHALL be a one-cycle pulse per accepted valid transition; drives an up/down counter's enable.
REQ-011 direction  output  1  SHALL indicate the last accepted step's sense: 1 = up, 0 = down; drives the counter's direction.
REQ-012 position  output  8  SHALL be the accumulated step count.
REQ-013 error  output  1  SHALL be a sticky flag for illegal (two-bit) transitions.

Function
REQ-014 Each phase SHALL pass through SYNC_STAGES registered flops before any other use.
REQ-015 The filtered phase pair {A,B} SHALL update only after the synchronized pair holds one value for FILTER_LEN consecutive clock edges; shorter pulses SHALL be ignored.
REQ-016 The decoder state SHALL be the last accepted filtered pair, with states S00, S01, S11, S10.
REQ-017 Up sequence: S00->S01->S11->S10->S00. Each such transition SHALL produce step=1, direction=1, position+1.
REQ-018 Down sequence: S00->S10->S11->S01->S00. Each such transition SHALL produce step=1, direction=0, position-1.
REQ-019 A change of both bits (S00<->S11, S01<->S10) SHALL set error=1 and adopt the new state, with no step, no position change and direction held.
REQ-020 Position arithmetic SHALL be modulo 256: 255+1 -> 0; 0-1 -> 255.
REQ-021 Latency: a phase change meeting setup before clock edge 1 SHALL produce step at edge SYNC_STAGES+FILTER_LEN+1, with position and direction updated on the same edge.
REQ-022 step SHALL be high for exactly one cycle per accepted transition; consecutive transitions MAY produce back-to-back pulses.
REQ-023 With enable=0, the state SHALL still track transitions and error detection SHALL still operate; step SHALL stay 0, and position and direction SHALL hold.
REQ-024 clear=1 SHALL set position to 0 on that edge, overriding a coincident increment or decrement; step and direction SHALL still report the coincident transition.
REQ-025 err_clr=1 SHALL clear error, unless an illegal transition is detected on the same edge, in which case error SHALL remain 1.
REQ-026 The first filtered pair accepted after reset SHALL be adopted as the state without producing step or error.

Reset
REQ-027 While rst=0, all outputs SHALL be forced immediately, independent of clk: step=0, direction=1, position=0, error=0.
REQ-028 While rst=0, synchronizer flops, filter counters and state SHALL be forced to 0, and the first-sample flag SHALL be set.
REQ-029 Reset assertion mid-sequence SHALL abandon any pending filtered value; no step SHALL be emitted for it after release.

Verification
REQ-030 Bench SHALL cover each of the following directed scenarios:
- Reset release with A=B=0, then 4 clean up transitions spaced 10 cycles apart -> 4 single-cycle step pulses, direction=1, position 0->4, each pulse at edge 6 after the input change (defaults).
- Position=1, then 3 down transitions -> position 1->0->255->254; direction=0 on every pulse.
- Glitch on A lasting 2 cycles (FILTER_LEN=3) -> no step, no position change, no error.
- Jump S00->S11 -> error=1, no step, position unchanged. Assert err_clr -> error=0. Repeat the jump with err_clr held high -> error stays 1.
- enable=0 during 3 up transitions, then enable=1 and 1 up transition -> only 1 step pulse, position+1, no error.
- Reset asserted asynchronously mid-filter with inputs at 11, then released -> outputs reset immediately; first accepted pair 11 is adopted silently (no step, no error); clear coincident with a later step -> position=0 and step pulses.
